dmem_responder: RTL and testbench

Data-side bus responder: the memory end of the CPU data port (DAD/MREQ/WRITE/SIZE/DDT/ACKD_n). It latches each request, inserts a configurable number of wait states, and then for one cycle asserts ACKD_n. On a read it drives the addressed word onto the shared DDT bus; on a write it merges byte lanes into a word-organised RAM. It sits beside the CPU top level in system benches and FPGA builds, replacing the behavioural data memory.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_lane_merge.sv | 43 ++++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types for the data-memory responder (states, access
//               size encodings, byte-enable type and lane-enable helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef logic [3:0] byte_en_t;

  // Big-endian: byte offset 0 is bits [31:24], i.e. enable bit 3.
  function automatic byte_en_t size_to_be(input logic [1:0] size,
                                          input logic [1:0] offset);
    byte_en_t be;
    case (size)
      SZ_HALF: be = offset[1] ? 4'b0011 : 4'b1100;
      SZ_BYTE: be = 4'b1000 >> offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_merge.sv
// ============================================================================
// Module      : dmem_lane_merge
// Description : Combinational store-lane merge: byte enables from size/offset
//               and the old word with the right-aligned store data merged in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old,
  output logic [3:0]  o_be,
  output logic [31:0] o_word
);

  byte_en_t    w_be;
  logic [31:0] w_lanes;

  always_comb begin
    w_be = size_to_be(i_size, i_offset);
    case (i_size)
      SZ_HALF: w_lanes = {2{i_wdata[15:0]}};
      SZ_BYTE: w_lanes = {4{i_wdata[7:0]}};
      default: w_lanes = i_wdata;
    endcase
  end

  always_comb begin
    o_word = i_old;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) o_word[8*i +: 8] = w_lanes[8*i +: 8];
    end
  end

  assign o_be = w_be;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Data-side bus responder with wait states, one-cycle ACKD_n,
//               tristate read data and byte-lane store merge into word RAM.
//               Optional DMEM_BOUNDS_EN: out-of-range addresses read as zero
//               and discard stores; otherwise addresses wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DAD,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  inout  wire  [31:0] DDT,
  output logic        ACKD_n
);

  localparam int         c_AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [c_AW-1:0]  r_idx;
  logic [1:0]       r_off;
  logic [1:0]       r_size;
  logic             r_write;
  logic             r_oob;
  logic             r_ackd_n;
  logic             r_oe;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_req_oob;
  logic             w_unused_hi;
  logic [31:0]      w_old;
  logic [31:0]      w_rdata;
  logic [31:0]      w_merged;
  logic [3:0]       w_be;
  logic             w_commit;

`ifdef DMEM_BOUNDS_EN
  assign w_req_oob = |DAD[31:c_AW+2];
`else
  assign w_req_oob = 1'b0;
`endif
  assign w_unused_hi = ^DAD[31:c_AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_off    <= 2'd0;
      r_size   <= SZ_WORD;
      r_write  <= 1'b0;
      r_oob    <= 1'b0;
      r_ackd_n <= 1'b1;
      r_oe     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ackd_n <= 1'b1;
          r_oe     <= 1'b0;
          if (MREQ) begin
            r_idx   <= DAD[c_AW+1:2];
            r_off   <= DAD[1:0];
            r_size  <= SIZE;
            r_write <= WRITE;
            r_oob   <= w_req_oob;
            r_cnt   <= c_WAIT_LOAD;
            if (c_WAIT_LOAD == 4'd0) begin
              r_state  <= ST_ACK;
              r_ackd_n <= 1'b0;
              r_oe     <= ~WRITE;
            end else begin
              r_state  <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A request withdrawn on the expiry cycle is still an abort.
          if (!MREQ) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt <= 4'd1) begin
            r_state  <= ST_ACK;
            r_cnt    <= 4'd0;
            r_ackd_n <= 1'b0;
            r_oe     <= ~r_write;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          r_state  <= ST_IDLE;
          r_ackd_n <= 1'b1;
          r_oe     <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cnt    <= 4'd0;
          r_ackd_n <= 1'b1;
          r_oe     <= 1'b0;
        end
      endcase
    end
  end

  assign w_old    = r_mem[r_idx];
  assign w_rdata  = r_oob ? 32'h0000_0000 : w_old;
  assign w_commit = (r_state == ST_ACK) && r_write && !r_oob;

  dmem_lane_merge u_lane_merge (
    .i_size   (r_size),
    .i_offset (r_off),
    .i_wdata  (DDT),
    .i_old    (w_old),
    .o_be     (w_be),
    .o_word   (w_merged)
  );

  // Store data is sampled from DDT on the edge that closes the ACK cycle.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[r_idx][8*i +: 8] <= w_merged[8*i +: 8];
      end
    end
  end

  assign DDT    = r_oe ? w_rdata : 32'hzzzz_zzzz;
  assign ACKD_n = r_ackd_n;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder (WAIT_CYCLES 0 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] tb_dad   [2];
  logic        tb_mreq  [2];
  logic        tb_write [2];
  logic [1:0]  tb_size  [2];
  logic        tb_oe    [2];
  logic [31:0] tb_wd    [2];

  wire  [31:0] ddt0;
  wire  [31:0] ddt1;
  wire         ack0;
  wire         ack1;

  // Pull-ups make an undriven bus read back as all ones.
  localparam logic [31:0] c_HIZ = 32'hFFFF_FFFF;

  assign ddt0 = tb_oe[0] ? tb_wd[0] : 32'hzzzz_zzzz;
  assign ddt1 = tb_oe[1] ? tb_wd[1] : 32'hzzzz_zzzz;

  for (genvar i = 0; i < 32; i++) begin : g_pu
    pullup (ddt0[i]);
    pullup (ddt1[i]);
  end

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .DAD(tb_dad[0]), .MREQ(tb_mreq[0]),
    .WRITE(tb_write[0]), .SIZE(tb_size[0]), .DDT(ddt0), .ACKD_n(ack0)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .DAD(tb_dad[1]), .MREQ(tb_mreq[1]),
    .WRITE(tb_write[1]), .SIZE(tb_size[1]), .DDT(ddt1), .ACKD_n(ack1)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic get_ack(input int u);
    return (u == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [31:0] get_ddt(input int u);
    return (u == 0) ? ddt0 : ddt1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, act, exp);
    end
  endtask

  // One complete access; checks ack latency, one-cycle pulse and bus release.
  task automatic access(input int u, input bit wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rd);
    int lat;
    bit got;
    @(negedge clk);
    tb_dad[u] = addr; tb_write[u] = wr; tb_size[u] = sz;
    tb_mreq[u] = 1'b1; tb_oe[u] = wr; tb_wd[u] = data;
    lat = 0; got = 1'b0; rd = '0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (get_ack(u) == 1'b0) begin
        got = 1'b1; lat = n; rd = get_ddt(u);
      end
    end
    tb_mreq[u] = 1'b0;
    check("ack_latency", 32'(lat), (u == 0) ? 32'd1 : 32'd2);
    @(negedge clk);
    check("ack_width", {31'd0, get_ack(u)}, 32'd1);
    if (!wr) check("ddt_release", get_ddt(u), c_HIZ);
    tb_oe[u] = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rd;
    bit seen;
    bit got;

    vecs[0]  = '{1'b1, 2'b00, 32'h10, 32'h1234_5678, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 32'h10, 32'h0,         32'h1234_5678};
    vecs[2]  = '{1'b1, 2'b00, 32'h20, 32'h0,         32'h0};
    vecs[3]  = '{1'b1, 2'b10, 32'h21, 32'h1234_56AA, 32'h0};
    vecs[4]  = '{1'b1, 2'b01, 32'h22, 32'hFFFF_BEEF, 32'h0};
    vecs[5]  = '{1'b0, 2'b00, 32'h20, 32'h0,         32'h00AA_BEEF};
    vecs[6]  = '{1'b1, 2'b00, 32'h30, 32'hCAFE_F00D, 32'h0};
    vecs[7]  = '{1'b0, 2'b10, 32'h31, 32'h0,         32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 2'b10, 32'h30, 32'h0000_0011, 32'h0};
    vecs[9]  = '{1'b1, 2'b10, 32'h33, 32'h0000_0022, 32'h0};
    vecs[10] = '{1'b1, 2'b01, 32'h31, 32'h0000_3344, 32'h0};
    vecs[11] = '{1'b0, 2'b01, 32'h30, 32'h0,         32'h3344_F022};
    vecs[12] = '{1'b1, 2'b11, 32'h36, 32'hDEAD_BEEF, 32'h0};
    vecs[13] = '{1'b0, 2'b00, 32'h34, 32'h0,         32'hDEAD_BEEF};
    vecs[14] = '{1'b1, 2'b10, 32'h12, 32'h0000_00CD, 32'h0};
    vecs[15] = '{1'b0, 2'b00, 32'h10, 32'h0,         32'h1234_CD78};

    for (int u = 0; u < 2; u++) begin
      tb_dad[u] = '0; tb_mreq[u] = 1'b0; tb_write[u] = 1'b0;
      tb_size[u] = 2'b00; tb_oe[u] = 1'b0; tb_wd[u] = '0;
    end

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_ack0", {31'd0, ack0}, 32'd1);
    check("rst_ack1", {31'd0, ack1}, 32'd1);
    check("rst_ddt0", ddt0, c_HIZ);
    check("rst_ddt1", ddt1, c_HIZ);
    rst = 1'b0;

    // Directed vectors, WAIT_CYCLES=1
    for (int i = 0; i < 16; i++) begin
      access(1, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].data, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // Abort: MREQ dropped in the (expiring) WAIT cycle of a store
    @(negedge clk);
    tb_dad[1] = 32'h30; tb_write[1] = 1'b1; tb_size[1] = 2'b00;
    tb_mreq[1] = 1'b1; tb_oe[1] = 1'b1; tb_wd[1] = 32'h9999_9999;
    @(negedge clk);
    seen = (ack1 == 1'b0);
    tb_mreq[1] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (ack1 == 1'b0) seen = 1'b1;
    end
    tb_oe[1] = 1'b0;
    check("abort_no_ack", {31'd0, seen}, 32'd0);
    access(1, 1'b0, 2'b00, 32'h30, 32'h0, rd);
    check("abort_word_kept", rd, 32'h3344_F022);

    // Reset during the WAIT of a store
    access(1, 1'b1, 2'b00, 32'h40, 32'h0BAD_F00D, rd);
    @(negedge clk);
    tb_dad[1] = 32'h40; tb_write[1] = 1'b1; tb_size[1] = 2'b00;
    tb_mreq[1] = 1'b1; tb_oe[1] = 1'b1; tb_wd[1] = 32'h5555_5555;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait_ack", {31'd0, ack1}, 32'd1);
    tb_mreq[1] = 1'b0;
    @(negedge clk);
    tb_oe[1] = 1'b0;
    rst = 1'b0;
    access(1, 1'b0, 2'b00, 32'h40, 32'h0, rd);
    check("rst_word_kept", rd, 32'h0BAD_F00D);

    // Reset in the ACK cycle of a read releases the bus asynchronously
    @(negedge clk);
    tb_dad[1] = 32'h10; tb_write[1] = 1'b0; tb_size[1] = 2'b00; tb_mreq[1] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 4 && !got; n++) begin
      @(negedge clk);
      if (ack1 == 1'b0) got = 1'b1;
    end
    check("rst_ack_seen", {31'd0, got}, 32'd1);
    check("rst_pre_ddt", ddt1, 32'h1234_CD78);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_ack", {31'd0, ack1}, 32'd1);
    check("rst_async_ddt", ddt1, c_HIZ);
    tb_mreq[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // WAIT_CYCLES=0, MREQ held for three back-to-back loads
    access(0, 1'b1, 2'b00, 32'h8, 32'hA5A5_0001, rd);
    @(negedge clk);
    tb_dad[0] = 32'h8; tb_write[0] = 1'b0; tb_size[0] = 2'b00; tb_mreq[0] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n % 2 == 0) begin
        check($sformatf("b2b%0d_ack_low", n), {31'd0, ack0}, 32'd0);
        check($sformatf("b2b%0d_rdata", n), ddt0, 32'hA5A5_0001);
      end else begin
        check($sformatf("b2b%0d_ack_high", n), {31'd0, ack0}, 32'd1);
        check($sformatf("b2b%0d_hiz", n), ddt0, c_HIZ);
      end
    end
    tb_mreq[0] = 1'b0;
    @(negedge clk);

    // Address range: 0x1000 is beyond 1024 words
    access(1, 1'b1, 2'b00, 32'h0, 32'h1111_2222, rd);
    access(1, 1'b1, 2'b00, 32'h1000, 32'h7777_8888, rd);
    access(1, 1'b0, 2'b00, 32'h0, 32'h0, rd);
`ifdef DMEM_BOUNDS_EN
    check("oob_word0", rd, 32'h1111_2222);
`else
    check("wrap_word0", rd, 32'h7777_8888);
`endif
    access(1, 1'b0, 2'b00, 32'h1000, 32'h0, rd);
`ifdef DMEM_BOUNDS_EN
    check("oob_read", rd, 32'h0000_0000);
`else
    check("wrap_read", rd, 32'h7777_8888);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
